// File: rtl/sync_master.sv
// ---------------------------------------------------------------------------
// sync_master
//
// Runs a chain of four-phase sync/ack handshakes with a slave. The first word
// sent is the seed; each later word is the previous slave reply, resized to
// the slave input width. The run ends after n_iter complete handshakes, or it
// aborts when a handshake phase waits TIMEOUT cycles without a response.
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   start        run request, only looked at while idle
//   n_iter       number of chained transactions, captured with start
//   seed         first word for the slave, captured with start
//   busy         high while a run is in progress
//   done         one-cycle pulse when a run ends (normal or aborted)
//   timeout_err  set by an aborted run, held until the next accepted start
//   result       last word captured from the slave
//   iter_count   completed transactions in the current or last run
//   sync         handshake request to the slave
//   ack          handshake acknowledge from the slave
//   slave_din    word presented to the slave
//   slave_dout   word returned by the slave
// ---------------------------------------------------------------------------
module sync_master #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] n_iter,
    input  logic [IN_WIDTH-1:0]  seed,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [OUT_WIDTH-1:0] result,
    output logic [CNT_WIDTH-1:0] iter_count,
    output logic                 sync,
    input  logic                 ack,
    output logic [IN_WIDTH-1:0]  slave_din,
    input  logic [OUT_WIDTH-1:0] slave_dout
);

    // Wide enough to hold the value TIMEOUT itself.
    localparam int WAIT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        REL   = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  n_target;
    logic [CNT_WIDTH-1:0]  n_target_next;
    logic [CNT_WIDTH-1:0]  iter_count_next;
    logic [CNT_WIDTH-1:0]  iter_inc;
    logic [OUT_WIDTH-1:0]  result_next;
    logic [IN_WIDTH-1:0]   slave_din_next;
    logic                  timeout_err_next;
    logic                  done_next;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic [WAIT_WIDTH-1:0] wait_next;
    logic [WAIT_WIDTH-1:0] wait_inc;

    // sync is only ever high in REQ, so it can never overlap a cycle in
    // which REL or ABORT is looking for ack to go low.
    assign sync     = (state == REQ);
    assign busy     = (state != IDLE);
    assign iter_inc = iter_count + CNT_WIDTH'(1);
    assign wait_inc = wait_cnt + WAIT_WIDTH'(1);

    // State and datapath registers. Reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            n_target    <= '0;
            iter_count  <= '0;
            result      <= '0;
            slave_din   <= '0;
            timeout_err <= 1'b0;
            done        <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_next;
            n_target    <= n_target_next;
            iter_count  <= iter_count_next;
            result      <= result_next;
            slave_din   <= slave_din_next;
            timeout_err <= timeout_err_next;
            done        <= done_next;
            wait_cnt    <= wait_next;
        end
    end

    // Next-state and next-datapath logic. slave_din is only reloaded on the
    // transitions into REQ, which keeps it constant while sync is high.
    // In REQ and REL an arriving response takes priority over the timeout.
    always_comb begin
        state_next       = state;
        n_target_next    = n_target;
        iter_count_next  = iter_count;
        result_next      = result;
        slave_din_next   = slave_din;
        timeout_err_next = timeout_err;
        done_next        = 1'b0;
        wait_next        = wait_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    iter_count_next  = '0;
                    timeout_err_next = 1'b0;
                    if (n_iter != '0) begin
                        n_target_next  = n_iter;
                        slave_din_next = seed;
                        wait_next      = '0;
                        state_next     = REQ;
                    end else begin
                        // Empty run: the seed is the answer.
                        result_next = OUT_WIDTH'(seed);
                        done_next   = 1'b1;
                    end
                end
            end

            REQ: begin
                if (ack) begin
                    result_next = slave_dout;
                    wait_next   = '0;
                    state_next  = REL;
                end else if (wait_inc == WAIT_LIMIT) begin
                    timeout_err_next = 1'b1;
                    state_next       = ABORT;
                end else begin
                    wait_next = wait_inc;
                end
            end

            REL: begin
                if (!ack) begin
                    iter_count_next = iter_inc;
                    if (iter_inc == n_target) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        // Chain the reply back in as the next request word.
                        slave_din_next = IN_WIDTH'(result);
                        wait_next      = '0;
                        state_next     = REQ;
                    end
                end else if (wait_inc == WAIT_LIMIT) begin
                    timeout_err_next = 1'b1;
                    state_next       = ABORT;
                end else begin
                    wait_next = wait_inc;
                end
            end

            ABORT: begin
                // Leave only once the slave has released ack, so the next
                // run starts from a clean handshake.
                if (!ack) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_master.sv
// ---------------------------------------------------------------------------
// tb_sync_master
//
// Self-checking bench for sync_master with a 32-bit slave input, an 8-bit
// slave output and TIMEOUT = 10. A behavioural slave answers each request
// with ((word ^ key) + 1) truncated to 8 bits, after an optional random
// delay; it can also be told never to answer or be driven by hand.
// ---------------------------------------------------------------------------
module tb_sync_master;

    localparam int IN_W   = 32;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 16;
    localparam int TO     = 10;
    localparam int BUDGET = 400;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_DEAD   = 1;
    localparam int MODE_MANUAL = 2;

    logic             clock;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] n_iter;
    logic [IN_W-1:0]  seed;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [OUT_W-1:0] result;
    logic [CNT_W-1:0] iter_count;
    logic             sync;
    logic             ack;
    logic [IN_W-1:0]  slave_din;
    logic [OUT_W-1:0] slave_dout;

    int               tests;
    int               failures;
    logic             prev_sync;
    logic [IN_W-1:0]  prev_din;

    int               slave_mode;
    int               max_delay;
    logic [31:0]      slave_key;
    logic             manual_ack;
    logic [7:0]       manual_dout;
    logic [31:0]      sent_q[$];

    typedef struct {
        logic [31:0] seed_v;
        logic [15:0] n_v;
        logic [7:0]  exp_result;
        logic [15:0] exp_iter;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    sync_master #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W),
        .CNT_WIDTH (CNT_W),
        .TIMEOUT   (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .n_iter      (n_iter),
        .seed        (seed),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .result      (result),
        .iter_count  (iter_count),
        .sync        (sync),
        .ack         (ack),
        .slave_din   (slave_din),
        .slave_dout  (slave_dout)
    );

    // 10-unit clock period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hang guard: a stuck run ends the simulation with a failure line.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Slave model. It looks at sync between edges and answers one edge
    // later, i.e. it behaves like a registered slave. The reply word is
    // produced when ack rises, and every word it accepts is logged.
    initial begin : slave_model
        logic        s_sync;
        logic [31:0] s_din;
        int          wait_left;
        bit          pending;
        ack        = 1'b0;
        slave_dout = '0;
        wait_left  = 0;
        pending    = 1'b0;
        forever begin
            @(negedge clock);
            s_sync = sync;
            s_din  = slave_din;
            if (slave_mode == MODE_MANUAL) begin
                ack        = manual_ack;
                slave_dout = manual_dout;
            end else begin
                @(posedge clock);
                #1;
                if (slave_mode == MODE_DEAD) begin
                    ack = 1'b0;
                end else if (s_sync != ack) begin
                    if (!pending) begin
                        pending   = 1'b1;
                        wait_left = int'($urandom_range(max_delay, 0));
                    end
                    if (wait_left == 0) begin
                        if (s_sync) begin
                            slave_dout = 8'((s_din ^ slave_key) + 32'd1);
                            sent_q.push_back(s_din);
                        end
                        ack     = s_sync;
                        pending = 1'b0;
                    end else begin
                        wait_left--;
                    end
                end else begin
                    pending = 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock and sample #1 after the edge. Every step also checks
    // that slave_din holds while sync is high and only moves when sync rises.
    task automatic tick();
        @(posedge clock);
        #1;
        if (!reset) begin
            if (prev_sync && sync)
                check_output("din_stable_under_sync", slave_din, prev_din);
            else if (!(sync && !prev_sync))
                check_output("din_moves_only_with_sync", slave_din, prev_din);
        end
        prev_sync = sync;
        prev_din  = slave_din;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},   busy, 0);
        check_output({tag, "_done"},   done, 0);
        check_output({tag, "_err"},    timeout_err, 0);
        check_output({tag, "_result"}, result, 0);
        check_output({tag, "_iter"},   iter_count, 0);
        check_output({tag, "_sync"},   sync, 0);
        check_output({tag, "_din"},    slave_din, 0);
    endtask

    // One complete run: start, wait for done, check the end state and that
    // done is a single-cycle pulse. exp_lat < 0 skips the latency check.
    task automatic apply_stimulus(input logic [31:0] s, input logic [15:0] n,
                                  input logic [7:0] exp_res, input logic [15:0] exp_iter,
                                  input int exp_lat);
        int lat;
        int base;
        base   = sent_q.size();
        start  = 1'b1;
        seed   = s;
        n_iter = n;
        tick();
        start = 1'b0;
        check_output("busy_after_start", busy, (n != 0));
        check_output("sync_after_start", sync, (n != 0));
        check_output("err_cleared_on_start", timeout_err, 0);
        lat = 0;
        while (!done && lat < BUDGET) begin
            tick();
            lat++;
        end
        check_output("done_seen", done, 1);
        if (exp_lat >= 0)
            check_output("latency", lat, exp_lat);
        check_output("result", result, exp_res);
        check_output("iter_count", iter_count, exp_iter);
        check_output("err_after_run", timeout_err, 0);
        check_output("busy_after_done", busy, 0);
        if (n == 0)
            check_output("no_handshake", sent_q.size() - base, 0);
        tick();
        check_output("done_single_pulse", done, 0);
        check_output("sync_idle", sync, 0);
    endtask

    initial begin : main
        int          lat;
        int          cnt;
        int          dcount;
        int          base;
        logic [31:0] s;
        logic [15:0] n;
        logic [31:0] v;
        logic [7:0]  r;
        logic [31:0] exp_q[$];

        tests       = 0;
        failures    = 0;
        prev_sync   = 1'b0;
        prev_din    = '0;
        slave_mode  = MODE_NORMAL;
        max_delay   = 0;
        slave_key   = 32'd0;
        manual_ack  = 1'b0;
        manual_dout = 8'h00;
        reset       = 1'b1;
        start       = 1'b0;
        n_iter      = '0;
        seed        = '0;

        vecs[0] = '{32'd5,          16'd3, 8'd8,  16'd3, 12};
        vecs[1] = '{32'd7,          16'd0, 8'd7,  16'd0, 0};
        vecs[2] = '{32'h0000_00FE,  16'd3, 8'h01, 16'd3, 12};
        vecs[3] = '{32'h1234_5678,  16'd1, 8'h79, 16'd1, 4};
        vecs[4] = '{32'd0,          16'd5, 8'd5,  16'd5, 20};
        vecs[5] = '{32'h0000_ABCD,  16'd0, 8'hCD, 16'd0, 0};

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Table runs; the first one starts on the first edge out of reset.
        for (int i = 0; i < 6; i++)
            apply_stimulus(vecs[i].seed_v, vecs[i].n_v, vecs[i].exp_result,
                           vecs[i].exp_iter, vecs[i].exp_lat);

        // Narrow reply chained back into a wide request word.
        base = sent_q.size();
        apply_stimulus(32'h0000_01FF, 16'd2, 8'h01, 16'd2, 8);
        check_output("w_send_count", sent_q.size() - base, 2);
        if (sent_q.size() >= base + 2) begin
            check_output("w_first_send", sent_q[base], 32'h0000_01FF);
            check_output("w_second_send", sent_q[base + 1], 32'h0000_0000);
        end

        // Reset while the second request is outstanding, then restart.
        start  = 1'b1;
        seed   = 32'd20;
        n_iter = 16'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_output("mid_sync", sync, 1);
        check_output("mid_iter", iter_count, 1);
        check_output("mid_result", result, 21);
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        apply_stimulus(32'd20, 16'd2, 8'd22, 16'd2, 8);

        // Slave never answers: abort after TO cycles of sync.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        slave_mode = MODE_DEAD;
        start  = 1'b1;
        seed   = 32'd3;
        n_iter = 16'd2;
        tick();
        start = 1'b0;
        cnt = 0;
        while (sync && cnt < 50) begin
            tick();
            cnt++;
        end
        check_output("to_sync_cycles", cnt, TO);
        check_output("to_err_set", timeout_err, 1);
        check_output("to_busy_in_abort", busy, 1);
        check_output("to_no_done_yet", done, 0);
        tick();
        check_output("to_done", done, 1);
        check_output("to_busy_cleared", busy, 0);
        check_output("to_iter", iter_count, 0);
        check_output("to_result", result, 0);
        tick();
        check_output("to_done_single", done, 0);
        check_output("to_err_held", timeout_err, 1);
        slave_mode = MODE_NORMAL;
        apply_stimulus(32'd9, 16'd1, 8'd10, 16'd1, 4);

        // Slave holds ack high: timeout in REL, abort waits for ack to drop.
        slave_mode  = MODE_MANUAL;
        manual_ack  = 1'b0;
        manual_dout = 8'h5A;
        start  = 1'b1;
        seed   = 32'd1;
        n_iter = 16'd3;
        tick();
        start = 1'b0;
        manual_ack = 1'b1;
        tick();
        check_output("rel_sync_low", sync, 0);
        check_output("rel_result", result, 8'h5A);
        cnt = 0;
        while (!timeout_err && cnt < 50) begin
            tick();
            cnt++;
        end
        check_output("rel_timeout_cycles", cnt, TO);
        repeat (3) begin
            tick();
            check_output("abort_waits_done", done, 0);
            check_output("abort_waits_busy", busy, 1);
            check_output("abort_sync_low", sync, 0);
        end
        manual_ack = 1'b0;
        tick();
        check_output("abort_done", done, 1);
        check_output("abort_busy", busy, 0);
        check_output("abort_iter", iter_count, 0);
        check_output("abort_result", result, 8'h5A);
        check_output("abort_err", timeout_err, 1);
        tick();
        check_output("abort_done_single", done, 0);
        slave_mode = MODE_NORMAL;

        // start held high with changing operands during a 2-iteration run.
        base   = sent_q.size();
        start  = 1'b1;
        seed   = 32'd40;
        n_iter = 16'd2;
        tick();
        lat = 0;
        while (!done && lat < BUDGET) begin
            start  = 1'b1;
            seed   = $urandom;
            n_iter = 16'($urandom_range(5, 1));
            tick();
            lat++;
        end
        start = 1'b0;
        dcount = done ? 1 : 0;
        check_output("spam_latency", lat, 8);
        check_output("spam_result", result, 8'd42);
        check_output("spam_iter", iter_count, 2);
        repeat (10) begin
            tick();
            if (done) dcount++;
        end
        check_output("spam_done_pulses", dcount, 1);
        check_output("spam_send_count", sent_q.size() - base, 2);
        check_output("spam_idle", busy, 0);

        // Random runs against a word-level model of the chained transform.
        for (int k = 0; k < 40; k++) begin
            max_delay = int'($urandom_range(3, 0));
            slave_key = $urandom;
            s = $urandom;
            n = 16'($urandom_range(6, 0));
            exp_q.delete();
            v = s;
            r = s[7:0];
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back(v);
                r = 8'((v ^ slave_key) + 32'd1);
                v = {24'd0, r};
            end
            base = sent_q.size();
            apply_stimulus(s, n, r, n, (max_delay == 0) ? 4 * int'(n) : -1);
            check_output("rand_send_count", sent_q.size() - base, exp_q.size());
            if (sent_q.size() - base == exp_q.size()) begin
                for (int i = 0; i < exp_q.size(); i++)
                    check_output("rand_send_word", sent_q[base + i], exp_q[i]);
            end
        end
        max_delay = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
